// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first.
// Operands arrive on an in_valid/in_ready handshake; the result leaves on an out_valid/out_ready handshake.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s, c_nx, last;

    assign s    = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign last = (cnt == CW'(WIDTH - 1));

    // Handshake flags come from the state register only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        c    <= cin;
                        cnt  <= '0;
                        sum  <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                    sum  <= {s, sum[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= c_nx;
                    cnt  <= cnt + 1'b1;
                    if (last) cout <= c_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm (WIDTH=8): arithmetic, latency, backpressure,
// ignored inputs during SHIFT and an asynchronous reset mid-operation.
module tb_serial_adder_fsm;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: load at the next edge, count SHIFT edges until out_valid,
    // hold out_ready low for `hold` cycles, then complete the output handshake.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tci, input int hold, input bit poke);
        logic [W:0] exp;
        int edges;
        exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < W + 4) begin
            if (edges == 1) begin
                chk({tag, " in_ready shift"}, 32'(in_ready), 32'd0);
                chk({tag, " busy shift"}, 32'(busy), 32'd1);
            end
            if (poke) begin
                in_valid = edges[0];
                a = ~ta; b = ~tb; cin = ~tci;
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 32'(edges), 32'(W));
        chk({tag, " sum"}, 32'(sum), 32'(exp[W-1:0]));
        chk({tag, " cout"}, 32'(cout), 32'(exp[W]));
        chk({tag, " busy done"}, 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " held valid"}, 32'(out_valid), 32'd1);
            chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " held sum"}, 32'({cout, sum}), 32'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " post sum kept"}, 32'({cout, sum}), 32'(exp));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        // Reset state
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sum", 32'({cout, sum}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic: 0x35+0x1A=0x04F, 0xFF+0x01=0x100, 0xFF+0xFF+1=0x1FF
        do_op("t1", 8'h35, 8'h1A, 1'b0, 0, 1'b0);
        do_op("t2a", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op("t2b", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        // Backpressure then an immediate follow-on op: 0x12+0x34+1=0x047
        do_op("t3", 8'hA5, 8'h5A, 1'b1, 5, 1'b0);
        do_op("t3next", 8'h12, 8'h34, 1'b1, 0, 1'b0);
        // in_valid toggling with different operands during SHIFT: 0x6C+0x93=0x0FF
        do_op("t4", 8'h6C, 8'h93, 1'b0, 1, 1'b1);

        // Asynchronous reset three edges into SHIFT
        a = 8'h55; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst in_ready", 32'(in_ready), 32'd1);
        chk("t5 rst out_valid", 32'(out_valid), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst sum", 32'({cout, sum}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("t5 after", 8'h80, 8'h80, 1'b0, 0, 1'b0);

        // Random operands and backpressure against a+b+cin
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op("rand", ra, rb, rc, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
